dmem_responder: RTL



---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder_if.sv
// Request/response handshake bundle between the multicycle core and the data-memory responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one RV64 load/store at a time with LATENCY wait cycles,
// sign/zero extension and error reporting over a valid/ready response.
module dmem_responder #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input logic             clk,
    input logic             reset,
    dmem_responder_if.slave bus
);
    localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W      = 4;
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) << 3;

    if (LATENCY > 15) begin : gLatencyCheck
        $error("dmem_responder: LATENCY must be 0..15");
    end

    typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

    stateT              state;
    stateT              stateNext;
    logic [CNT_W-1:0]   waitCnt;
    logic               reqReady;
    logic               respValid;
    logic [63:0]        respRdata;
    logic               respErr;

    logic               weQ;
    logic [2:0]         funct3Q;
    logic [63:0]        addrQ;
    logic [63:0]        wdataQ;

    logic               accept;
    logic               doAccess;
    logic               accWe;
    logic [2:0]         accFunct3;
    logic [63:0]        accAddr;
    logic [63:0]        accWdata;
    logic [IDX_W-1:0]   accIdx;
    logic               accErr;
    logic               misaligned;
    logic [7:0]         sizeMask;
    logic [7:0]         byteMask;
    logic [63:0]        storeData;
    logic [63:0]        shifted;
    logic [63:0]        loadData;

    logic [63:0]        mem [DEPTH];

    // State register; handshake outputs are registered from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            reqReady  <= 1'b1;
            respValid <= 1'b0;
        end else begin
            state     <= stateNext;
            reqReady  <= (stateNext == IDLE);
            respValid <= (stateNext == RESP);
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.req_valid) stateNext = (LATENCY == 0) ? RESP : WAIT;
            WAIT:    if (waitCnt == '0) stateNext = RESP;
            RESP:    if (bus.resp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        accept   = 1'b0;
        doAccess = 1'b0;
        case (state)
            IDLE: begin
                accept   = bus.req_valid;
                doAccess = bus.req_valid && (LATENCY == 0);
            end
            WAIT:    doAccess = (waitCnt == '0);
            default: ;
        endcase
    end

    // With zero latency the access happens on the accept edge, so use the live request.
    always_comb begin
        if (state == IDLE) begin
            accWe     = bus.req_we;
            accFunct3 = bus.req_funct3;
            accAddr   = bus.req_addr;
            accWdata  = bus.req_wdata;
        end else begin
            accWe     = weQ;
            accFunct3 = funct3Q;
            accAddr   = addrQ;
            accWdata  = wdataQ;
        end
    end

    always_comb begin
        accIdx = accAddr[IDX_W+2:3];
        case (accFunct3[1:0])
            2'd0:    begin misaligned = 1'b0;                 sizeMask = 8'h01; end
            2'd1:    begin misaligned = accAddr[0];           sizeMask = 8'h03; end
            2'd2:    begin misaligned = accAddr[1:0] != 2'd0; sizeMask = 8'h0F; end
            default: begin misaligned = accAddr[2:0] != 3'd0; sizeMask = 8'hFF; end
        endcase
        accErr = misaligned
              || (accAddr >= ADDR_LIMIT)
              || (accWe ? accFunct3[2] : (accFunct3 == 3'b111));
        byteMask  = sizeMask << accAddr[2:0];
        storeData = accWdata << {accAddr[2:0], 3'b000};
        shifted   = mem[accIdx] >> {accAddr[2:0], 3'b000};
        case (accFunct3)
            3'b000:  loadData = {{56{shifted[7]}},  shifted[7:0]};
            3'b001:  loadData = {{48{shifted[15]}}, shifted[15:0]};
            3'b010:  loadData = {{32{shifted[31]}}, shifted[31:0]};
            3'b011:  loadData = shifted;
            3'b100:  loadData = {56'd0, shifted[7:0]};
            3'b101:  loadData = {48'd0, shifted[15:0]};
            3'b110:  loadData = {32'd0, shifted[31:0]};
            default: loadData = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt   <= '0;
            respRdata <= '0;
            respErr   <= 1'b0;
        end else begin
            if (accept) begin
                weQ     <= bus.req_we;
                funct3Q <= bus.req_funct3;
                addrQ   <= bus.req_addr;
                wdataQ  <= bus.req_wdata;
                waitCnt <= (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);
            end else if (state == WAIT && waitCnt != '0) begin
                waitCnt <= waitCnt - CNT_W'(1);
            end
            if (doAccess) begin
                respRdata <= (accWe || accErr) ? '0 : loadData;
                respErr   <= accErr;
            end
        end
    end

    // Byte-lane write; storage is never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && doAccess && accWe && !accErr) begin
            for (int i = 0; i < 8; i++) begin
                if (byteMask[i]) mem[accIdx][8*i +: 8] <= storeData[8*i +: 8];
            end
        end
    end

    assign bus.req_ready  = reqReady;
    assign bus.resp_valid = respValid;
    assign bus.resp_rdata = respRdata;
    assign bus.resp_err   = respErr;
endmodule
